// File: rtl/siso_shift_rr_ctrl.sv
// Round-robin two-requester sequencer for an N-bit SISO shift chain.
// Each transfer shifts the granted word in MSB-first and captures the displaced word.
module siso_shift_rr_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  output logic [1:0]   gnt,
  output logic         sr_shift_en,
  output logic         sr_serial_in,
  input  logic         sr_serial_out,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rdata,
  output logic         rid
);
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          wid_q, wid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  tx_q, tx_d;
  logic [N-1:0]  rx_q, rx_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [N-1:0]  rdata_q, rdata_d;
  logic          rid_q, rid_d;
  logic          win;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wid_d   = wid_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    gnt_d   = 2'b00;
    rdata_d = rdata_q;
    rid_d   = rid_q;
    win     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // Pointer only breaks ties; a lone requester always wins.
          win     = (req == 2'b11) ? ptr_q : req[1];
          gnt_d   = win ? 2'b10 : 2'b01;
          tx_d    = win ? data1 : data0;
          wid_d   = win;
          ptr_d   = ~win;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        tx_d  = {tx_q[N-2:0], 1'b0};
        rx_d  = {rx_q[N-2:0], sr_serial_out};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          // Last capture lands in rdata directly, on the same edge.
          state_d = S_DONE;
          rdata_d = rx_d;
          rid_d   = wid_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      wid_q   <= 1'b0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      gnt_q   <= 2'b00;
      rdata_q <= '0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wid_q   <= wid_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
    end
  end

  assign gnt          = gnt_q;
  assign sr_shift_en  = (state_q == S_SHIFT);
  assign sr_serial_in = sr_shift_en & tx_q[N-1];
  assign busy         = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done         = (state_q == S_DONE);
  assign rdata        = rdata_q;
  assign rid          = rid_q;
endmodule

// File: tb/tb_siso_shift_rr_ctrl.sv
// Directed bench: models the SISO chain and checks grants, serial bits and swapped words.
module tb_siso_shift_rr_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [N-1:0] data0, data1;
  logic [1:0]   gnt;
  logic         sr_shift_en, sr_serial_in, sr_serial_out;
  logic         busy, done;
  logic [N-1:0] rdata;
  logic         rid;

  logic [N-1:0] chain;
  logic         load;
  logic [N-1:0] load_val;
  int           cyc = 0;
  int           checks = 0;
  int           errs = 0;
  int           last_wait = 0;
  int           last_done = 0;
  int           d_prev;

  siso_shift_rr_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .sr_shift_en(sr_shift_en), .sr_serial_in(sr_serial_in),
    .sr_serial_out(sr_serial_out), .busy(busy), .done(done),
    .rdata(rdata), .rid(rid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain model: shifts MSB-first when enabled, bit leaving is the MSB.
  always @(posedge clk) begin
    if (load) chain <= load_val;
    else if (sr_shift_en) chain <= {chain[N-2:0], sr_serial_in};
  end
  assign sr_serial_out = chain[N-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic xfer(input logic [1:0] rq, input bit hold, input logic [1:0] eg,
                      input logic [N-1:0] etx, input logic [N-1:0] erd,
                      input logic erid, input logic [1:0] late);
    int w;
    req = rq;
    step();
    w = 1;
    while (gnt == 2'b00 && w < 12) begin
      step();
      w++;
    end
    last_wait = w;
    chk("gnt", {30'd0, gnt}, {30'd0, eg});
    if (gnt == 2'b00) return;
    if (!hold) req = req & ~eg;
    for (int k = 0; k < N; k++) begin
      if (k > 0) chk("gnt_pulse", {30'd0, gnt}, 0);
      chk("shift_en", {31'd0, sr_shift_en}, 1);
      chk("serial_in", {31'd0, sr_serial_in}, {31'd0, etx[N-1-k]});
      chk("busy_shift", {31'd0, busy}, 1);
      chk("done_early", {31'd0, done}, 0);
      if (k == 1) req = req | late;
      step();
    end
    chk("shift_en_off", {31'd0, sr_shift_en}, 0);
    chk("serial_in_off", {31'd0, sr_serial_in}, 0);
    chk("done", {31'd0, done}, 1);
    chk("busy_done", {31'd0, busy}, 1);
    chk("rdata", {28'd0, rdata}, {28'd0, erd});
    chk("rid", {31'd0, rid}, {31'd0, erid});
    chk("gnt_done", {30'd0, gnt}, 0);
    last_done = cyc;
    step();
    chk("busy_idle", {31'd0, busy}, 0);
    chk("done_idle", {31'd0, done}, 0);
    chk("gnt_idle", {30'd0, gnt}, 0);
  endtask

  initial begin
    rst = 1'b1; req = 2'b11; data0 = 4'b1011; data1 = 4'b0001;
    load = 1'b0; load_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_en", {31'd0, sr_shift_en}, 0);
    chk("rst_sin", {31'd0, sr_serial_in}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rdata", {28'd0, rdata}, 0);
    chk("rst_rid", {31'd0, rid}, 0);
    rst = 1'b0;
    step();
    chk("first_gnt", {30'd0, gnt}, 32'd1);
    // Abort that transfer and preload the chain.
    rst = 1'b1; req = 2'b00; load = 1'b1; load_val = 4'b0110;
    step();
    load = 1'b0; rst = 1'b0;
    step();

    // Single transfer, then swap back.
    xfer(2'b01, 1'b0, 2'b01, 4'b1011, 4'b0110, 1'b0, 2'b00);
    xfer(2'b10, 1'b0, 2'b10, 4'b0001, 4'b1011, 1'b1, 2'b00);
    chk("chain_after_swap", {28'd0, chain}, 32'h1);

    // Contention: alternating grants, done every N+2 cycles.
    xfer(2'b11, 1'b1, 2'b01, 4'b1011, 4'b0001, 1'b0, 2'b00);
    d_prev = last_done;
    xfer(2'b11, 1'b1, 2'b10, 4'b0001, 4'b1011, 1'b1, 2'b00);
    chk("cont_wait1", last_wait, 1);
    chk("done_spacing1", last_done - d_prev, N + 2);
    d_prev = last_done;
    xfer(2'b11, 1'b1, 2'b01, 4'b1011, 4'b0001, 1'b0, 2'b00);
    chk("cont_wait2", last_wait, 1);
    chk("done_spacing2", last_done - d_prev, N + 2);
    d_prev = last_done;
    xfer(2'b11, 1'b1, 2'b10, 4'b0001, 4'b1011, 1'b1, 2'b00);
    chk("done_spacing3", last_done - d_prev, N + 2);
    req = 2'b00;
    step();

    // Busy masking: req1 raised mid-shift waits for the next IDLE.
    xfer(2'b01, 1'b0, 2'b01, 4'b1011, 4'b0001, 1'b0, 2'b10);
    xfer(2'b10, 1'b0, 2'b10, 4'b0001, 4'b1011, 1'b1, 2'b00);
    chk("mask_wait", last_wait, 1);

    // Mid-transfer asynchronous reset.
    req = 2'b01;
    step();
    chk("mr_gnt", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("mr_en", {31'd0, sr_shift_en}, 0);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_gnt0", {30'd0, gnt}, 0);
    chk("mr_rdata", {28'd0, rdata}, 0);
    chk("mr_sin", {31'd0, sr_serial_in}, 0);
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_no_done", {31'd0, done}, 0);
    end
    rst = 1'b0;
    step();
    chk("mr_regrant", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    repeat (N + 3) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
